bram_fifo_ctrl: RTL and testbench
=================================

Name: bram_fifo_ctrl

Overview:
- Single-clock synchronous FIFO controller that sits directly upstream of the simple dual-port BRAM.
- Drives the BRAM write port (ena/addra/dina) and read port (enb/addrb), and consumes its registered doutb.
- Exposes a push/pop FIFO interface with status flags to the pipeline.
- The integrator ties BRAM clka and clkb to the same clk and shares rst_n.

Parameters:
DATA_WIDTH, 32, FIFO/BRAM word width
ADDR_WIDTH, 10, BRAM address width; DEPTH = 2**ADDR_WIDTH entries
AF_LEVEL, DEPTH-4, almost_full asserts when count >= AF_LEVEL
AE_LEVEL, 4, almost_empty asserts when count <= AE_LEVEL

Ports:
clk  in  1  single clock for controller and BRAM
rst_n  in  1  synchronous reset, active-low
wr_en  in  1  push request
wr_data  in  DATA_WIDTH  push data
full  out  1  count == DEPTH
almost_full  out  1  count >= AF_LEVEL
rd_en  in  1  pop request
rd_data  out  DATA_WIDTH  pop data; meaningful only while rd_valid = 1
rd_valid  out  1  rd_data holds the word popped in the previous cycle
empty  out  1  count == 0
almost_empty  out  1  count <= AE_LEVEL
count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: a push was rejected
underflow  out  1  sticky: a pop was rejected
bram_ena  out  1  to BRAM ena
bram_addra  out  ADDR_WIDTH  to BRAM addra
bram_dina  out  DATA_WIDTH  to BRAM dina
bram_enb  out  1  to BRAM enb
bram_addrb  out  ADDR_WIDTH  to BRAM addrb
bram_doutb  in  DATA_WIDTH  from BRAM doutb (1-cycle registered read)

Behaviour:
- Single clock `clk`. Reset `rst_n` is synchronous and active-low.
- Reset (rst_n = 0 at a clk edge):
  - wr_ptr, rd_ptr, count, rd_valid, overflow and underflow all go to 0.
  - Resulting flags: empty = 1, almost_empty = 1, full = 0, almost_full = 0 (for AF_LEVEL > 0).
  - bram_ena and bram_enb are forced to 0 while rst_n = 0.
- Accept rules: wr_acc = wr_en & ~full; rd_acc = rd_en & ~empty. Both are evaluated on the registered count at the start of the cycle.
  - Push while full is rejected even if a pop is accepted in the same cycle.
  - Pop while empty is rejected even if a push is accepted in the same cycle.
- Write port (combinational):
  - bram_ena = wr_acc; bram_addra = wr_ptr; bram_dina = wr_data.
  - wr_ptr increments on wr_acc and wraps from DEPTH-1 to 0.
- Read port:
  - bram_enb = rd_acc; bram_addrb = rd_ptr.
  - rd_ptr increments on rd_acc and wraps from DEPTH-1 to 0.
  - Read latency is 1: rd_valid is rd_acc registered. rd_data = bram_doutb (pass-through).
  - rd_data holds its last value when no read occurs; consumers must qualify it with rd_valid.
- Occupancy:
  - count +1 on wr_acc only, -1 on rd_acc only, unchanged when both or neither.
  - full, empty, almost_full and almost_empty are combinational decodes of the count register, so they update the cycle after the accepting edge.
- Address collision: an accepted write and an accepted read never target the same address in the same cycle. Full blocks the write and empty blocks the read, so no read-during-write handling is needed.
- Errors:
  - overflow is set on the edge after wr_en & full; underflow is set on the edge after rd_en & empty.
  - Both stay at 1 until reset.
  - Rejected operations leave pointers, count and BRAM unchanged.
- Reset mid-operation:
  - Any in-flight read is discarded: rd_valid = 0 in the cycle after reset.
  - FIFO contents are logically lost, and BRAM data is not cleared.

Test Plan (DATA_WIDTH=32, ADDR_WIDTH=4, DEPTH=16, AF_LEVEL=12, AE_LEVEL=4):
1. Reset, push 0xA0..0xA2, then pop 3 -> count 3 before popping; rd_valid pulses 1 cycle after each pop with 0xA0, 0xA1, 0xA2 in order; empty = 1 afterwards.
2. Push 16 words 0x100+i -> full = 1 and almost_full = 1 from count 12; a 17th push sets overflow = 1; count stays 16; bram_ena = 0 on the rejected push.
3. Pop 8, push 8, pop 16 -> wr_ptr and rd_ptr wrap past 15; output order is strictly FIFO across the wrap; rd_data of the last pop = last pushed word.
4. Simultaneous push+pop with count = 5 -> count stays 5. With count = 16, push+pop gives a pop accepted, push rejected, count 15, overflow = 1. With count = 0, push+pop gives a push accepted, pop rejected, count 1, underflow = 1.
5. Pop on empty after reset -> underflow = 1 next cycle, bram_enb = 0, rd_valid = 0; underflow stays 1 until rst_n = 0.
6. Reset asserted the cycle after a pop is accepted with count = 6 -> rd_valid = 0, count = 0, empty = 1, pointers at 0; a following push/pop returns the new data.

Source files
------------

// File: rtl/bram_fifo_ctrl.sv
// Single-clock FIFO controller driving a simple dual-port BRAM; pop data arrives 1 cycle after rd_en.
// No stall path: pushes while full and pops while empty are dropped and flagged in sticky overflow/underflow.
module bram_fifo_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int AF_LEVEL   = (2**ADDR_WIDTH) - 4,
  parameter int AE_LEVEL   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  bram_ena,
  output logic [ADDR_WIDTH-1:0] bram_addra,
  output logic [DATA_WIDTH-1:0] bram_dina,
  output logic                  bram_enb,
  output logic [ADDR_WIDTH-1:0] bram_addrb,
  input  logic [DATA_WIDTH-1:0] bram_doutb
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_acc, rd_acc;

  // Flags decode the registered count, so acceptance never depends on the same-cycle opposite op.
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);

  always_comb begin
    wr_acc      = wr_en & ~full;
    rd_acc      = rd_en & ~empty;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_valid_d  = rd_acc;
    overflow_d  = overflow_q | (wr_en & full);
    underflow_d = underflow_q | (rd_en & empty);
    if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Enables are gated by rst_n so the BRAM sees no access while the pointers are being cleared.
  assign bram_ena   = wr_acc & rst_n;
  assign bram_addra = wr_ptr_q;
  assign bram_dina  = wr_data;
  assign bram_enb   = rd_acc & rst_n;
  assign bram_addrb = rd_ptr_q;

  assign rd_data   = bram_doutb;
  assign rd_valid  = rd_valid_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Bench for bram_fifo_ctrl at DEPTH=16: directed vector table, then queue-scoreboard sequences
// for fill/overflow, pointer wrap, simultaneous push/pop and reset during an in-flight read.
module tb_bram_fifo_ctrl;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        full, almost_full;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        empty, almost_empty;
  logic [4:0]  count;
  logic        overflow, underflow;
  logic        bram_ena;
  logic [3:0]  bram_addra;
  logic [31:0] bram_dina;
  logic        bram_enb;
  logic [3:0]  bram_addrb;
  logic [31:0] bram_doutb;

  int errors = 0;
  int checks = 0;

  bram_fifo_ctrl #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .AF_LEVEL(12), .AE_LEVEL(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_data(wr_data), .full(full), .almost_full(almost_full),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .empty(empty), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow),
    .bram_ena(bram_ena), .bram_addra(bram_addra), .bram_dina(bram_dina),
    .bram_enb(bram_enb), .bram_addrb(bram_addrb), .bram_doutb(bram_doutb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple dual-port BRAM with registered read port
  logic [31:0] mem [16];
  always @(posedge clk) begin
    if (bram_ena) mem[bram_addra] <= bram_dina;
    if (bram_enb) bram_doutb <= mem[bram_addrb];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic rst, wr; logic [31:0] wd; logic rd;
    logic ena, enb; logic [3:0] aa, ab;
    logic [4:0] cnt; logic full, af, empty, ae, rv; logic [31:0] rdata; logic ovf, unf;
  } vec_t;

  vec_t vt [13];

  // Scoreboard state for the sequences
  logic [31:0] q [$];
  logic        m_ovf = 1'b0;
  logic        m_unf = 1'b0;

  task automatic sb_step(input logic r, input logic w, input logic [31:0] d, input logic rd);
    int n;
    logic fl, em, wa, ra, erv;
    logic [31:0] edata;
    n = q.size();
    fl = (n == 16);
    em = (n == 0);
    wa = w & ~fl;
    ra = rd & ~em;
    erv = 1'b0;
    edata = '0;
    @(negedge clk);
    rst_n = r; wr_en = w; wr_data = d; rd_en = rd;
    #1;
    chk("sb_ena", 32'(bram_ena), 32'(r & wa));
    chk("sb_enb", 32'(bram_enb), 32'(r & ra));
    if (!r) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      erv = ra;
      if (ra) edata = q.pop_front();
      if (wa) q.push_back(d);
      m_ovf = m_ovf | (w & fl);
      m_unf = m_unf | (rd & em);
    end
    @(posedge clk);
    #1;
    chk("sb_count", 32'(count), 32'(q.size()));
    chk("sb_empty", 32'(empty), 32'(q.size() == 0));
    chk("sb_full", 32'(full), 32'(q.size() == 16));
    chk("sb_almost_full", 32'(almost_full), 32'(q.size() >= 12));
    chk("sb_almost_empty", 32'(almost_empty), 32'(q.size() <= 4));
    chk("sb_rd_valid", 32'(rd_valid), 32'(erv));
    if (erv) chk("sb_rd_data", rd_data, edata);
    chk("sb_overflow", 32'(overflow), 32'(m_ovf));
    chk("sb_underflow", 32'(underflow), 32'(m_unf));
  endtask

  initial begin
    //            rst   wr    wd        rd    ena   enb   aa    ab    cnt   full  af    empty ae    rv    rdata     ovf   unf
    vt[0]  = '{1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,    1'b0, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,    1'b0, 1'b1};
    vt[2]  = '{1'b1, 1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,    1'b0, 1'b1};
    vt[3]  = '{1'b1, 1'b1, 32'hA0,   1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,    1'b0, 1'b1};
    vt[4]  = '{1'b1, 1'b1, 32'hA1,   1'b0, 1'b1, 1'b0, 4'd1, 4'd0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,    1'b0, 1'b1};
    vt[5]  = '{1'b1, 1'b1, 32'hA2,   1'b0, 1'b1, 1'b0, 4'd2, 4'd0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,    1'b0, 1'b1};
    vt[6]  = '{1'b1, 1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 4'd3, 4'd0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA0,   1'b0, 1'b1};
    vt[7]  = '{1'b1, 1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 4'd3, 4'd1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA1,   1'b0, 1'b1};
    vt[8]  = '{1'b1, 1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 4'd3, 4'd2, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA2,   1'b0, 1'b1};
    vt[9]  = '{1'b1, 1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 4'd3, 4'd3, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,    1'b0, 1'b1};
    vt[10] = '{1'b0, 1'b1, 32'hEE,   1'b1, 1'b0, 1'b0, 4'd3, 4'd3, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,    1'b0, 1'b0};
    vt[11] = '{1'b1, 1'b1, 32'hB0,   1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,    1'b0, 1'b1};
    vt[12] = '{1'b1, 1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 4'd1, 4'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hB0,   1'b0, 1'b1};

    rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      rst_n = vt[i].rst; wr_en = vt[i].wr; wr_data = vt[i].wd; rd_en = vt[i].rd;
      #1;
      chk($sformatf("v%0d_ena", i), 32'(bram_ena), 32'(vt[i].ena));
      chk($sformatf("v%0d_enb", i), 32'(bram_enb), 32'(vt[i].enb));
      chk($sformatf("v%0d_addra", i), 32'(bram_addra), 32'(vt[i].aa));
      chk($sformatf("v%0d_addrb", i), 32'(bram_addrb), 32'(vt[i].ab));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_count", i), 32'(count), 32'(vt[i].cnt));
      chk($sformatf("v%0d_full", i), 32'(full), 32'(vt[i].full));
      chk($sformatf("v%0d_almost_full", i), 32'(almost_full), 32'(vt[i].af));
      chk($sformatf("v%0d_empty", i), 32'(empty), 32'(vt[i].empty));
      chk($sformatf("v%0d_almost_empty", i), 32'(almost_empty), 32'(vt[i].ae));
      chk($sformatf("v%0d_rd_valid", i), 32'(rd_valid), 32'(vt[i].rv));
      if (vt[i].rv) chk($sformatf("v%0d_rd_data", i), rd_data, vt[i].rdata);
      chk($sformatf("v%0d_overflow", i), 32'(overflow), 32'(vt[i].ovf));
      chk($sformatf("v%0d_underflow", i), 32'(underflow), 32'(vt[i].unf));
    end

    // Fill to full, push+pop while full, refill, then a rejected 17th push
    sb_step(1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 16; i++) sb_step(1'b1, 1'b1, 32'h100 + 32'(i), 1'b0);
    sb_step(1'b1, 1'b1, 32'hDEAD, 1'b1);
    chk("full_pushpop_count", 32'(count), 32'd15);
    chk("full_pushpop_overflow", 32'(overflow), 32'd1);
    sb_step(1'b1, 1'b1, 32'h110, 1'b0);
    sb_step(1'b1, 1'b1, 32'hBAD, 1'b0);
    chk("push17_count", 32'(count), 32'd16);

    // Pointer wrap: pop 8, push 8, pop 16
    for (int i = 0; i < 8; i++) sb_step(1'b1, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 8; i++) sb_step(1'b1, 1'b1, 32'h200 + 32'(i), 1'b0);
    for (int i = 0; i < 16; i++) sb_step(1'b1, 1'b0, 32'h0, 1'b1);
    chk("wrap_last_pop", rd_data, 32'h207);
    chk("wrap_empty", 32'(empty), 32'd1);

    // Simultaneous push+pop at count 5
    sb_step(1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) sb_step(1'b1, 1'b1, 32'h300 + 32'(i), 1'b0);
    sb_step(1'b1, 1'b1, 32'h305, 1'b1);
    chk("pushpop5_count", 32'(count), 32'd5);

    // Reset in the cycle after an accepted pop at count 6
    sb_step(1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 6; i++) sb_step(1'b1, 1'b1, 32'h400 + 32'(i), 1'b0);
    sb_step(1'b1, 1'b0, 32'h0, 1'b1);
    sb_step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_addra", 32'(bram_addra), 32'd0);
    chk("rst_addrb", 32'(bram_addrb), 32'd0);
    sb_step(1'b1, 1'b1, 32'hC0, 1'b0);
    sb_step(1'b1, 1'b0, 32'h0, 1'b1);
    chk("rst_new_data", rd_data, 32'hC0);

    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
